// File: rtl/irq_controller_pkg.sv
// Shared types and defaults for the interrupt controller: FSM state encoding,
// source/ID widths and a reference priority encoder.
package irq_controller_pkg;

  localparam int NSRC_DEF = 8;
  localparam int IDW_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  typedef struct packed {
    logic               valid;
    logic [IDW_DEF-1:0] index;
  } prio_t;

  // Lowest set index wins; valid=0 when the vector is empty.
  function automatic prio_t prio_enc(input logic [NSRC_DEF-1:0] vec);
    prio_t res;
    res = '0;
    for (int i = NSRC_DEF - 1; i >= 0; i--) begin
      if (vec[i]) begin
        res.valid = 1'b1;
        res.index = IDW_DEF'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder: source 0 has the highest priority.
module irq_prio_enc
  import irq_controller_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic [NSRC-1:0] vec,
  output logic            valid,
  output logic [IDW-1:0]  index
);

  always_comb begin
    valid = 1'b0;
    index = '0;
    // Walk downward so the lowest set index is the last one written.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (vec[i]) begin
        valid = 1'b1;
        index = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// 8-source interrupt controller: rising-edge capture into pending, enable mask,
// fixed-priority presentation to the CPU with ack / end-of-interrupt handshake.
//
// state   | meaning
// IDLE    | nothing presented; picks the highest-priority eligible source
// ASSERT  | interrupt=1, irq frozen, waiting for ack
// SERVICE | CPU in handler; interrupt=0 until eoi
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NSRC-1:0] req,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  input  logic            ack,
  input  logic            eoi,
  output logic            interrupt,
  output logic [IDW-1:0]  irq,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask,
  output logic            in_service,
  output logic            spurious
);

  irq_state_e      state, state_nxt;
  logic [NSRC-1:0] req_prev;
  logic [NSRC-1:0] req_edge;
  logic [NSRC-1:0] pending_q;
  logic [NSRC-1:0] mask_q;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] clr;
  logic [IDW-1:0]  irq_q, irq_nxt;
  logic            spurious_q;
  logic            spur_set;
  logic            win_valid;
  logic [IDW-1:0]  win_idx;

  assign req_edge = req & ~req_prev;
  assign eligible = pending_q & mask_q;

  irq_prio_enc #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) u_prio_enc (
    .vec   (eligible),
    .valid (win_valid),
    .index (win_idx)
  );

  always_comb begin
    state_nxt = state;
    irq_nxt   = irq_q;
    clr       = '0;
    spur_set  = 1'b0;
    case (state)
      IDLE: begin
        spur_set = ack | eoi;
        if (win_valid) begin
          state_nxt = ASSERT;
          irq_nxt   = win_idx;
        end
      end
      ASSERT: begin
        spur_set = eoi;
        // ack beats a same-cycle mask clear of the presented source.
        if (ack) begin
          clr[irq_q] = 1'b1;
          state_nxt  = SERVICE;
        end else if (!eligible[irq_q]) begin
          state_nxt = IDLE;
        end
      end
      SERVICE: begin
        spur_set = ack;
        if (eoi) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    req_prev <= req;
    if (!reset_n) begin
      state      <= IDLE;
      irq_q      <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      spurious_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      irq_q     <= irq_nxt;
      pending_q <= (pending_q & ~clr) | req_edge;
      if (mask_we) begin
        mask_q <= mask_wdata;
      end
      if (spur_set) begin
        spurious_q <= 1'b1;
      end
    end
  end

  assign interrupt  = (state == ASSERT);
  assign in_service = (state == SERVICE);
  assign irq        = irq_q;
  assign pending    = pending_q;
  assign mask       = mask_q;
  assign spurious   = spurious_q;

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- 8-source interrupt controller that drives the CPU's `interrupt` and `irq[2:0]` inputs.
- Latches rising edges on peripheral request lines into a pending register and applies a software-written enable mask.
- Presents the highest-priority enabled request to the CPU, holds it until the CPU acknowledges, then blocks further requests until end-of-interrupt (IRET).
- Instantiated beside the CPU in the system top; replaces the free-running periodic interrupt stimulus in the bench.

Parameters:
- NSRC, 8, number of request sources; must equal 2**IDW.
- IDW, 3, width of `irq`; matches the CPU's irq port.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- req  in  NSRC  peripheral request lines, rising-edge sensitive, synchronous to clock.
- mask_we  in  1  write strobe for the enable mask.
- mask_wdata  in  NSRC  new mask value; bit=1 enables that source.
- ack  in  1  one-cycle pulse from the CPU: interrupt taken (LR saved, PC vectored).
- eoi  in  1  one-cycle pulse from the CPU: IRET executed.
- interrupt  out  1  interrupt request to the CPU.
- irq  out  IDW  source ID of the presented interrupt; the CPU vectors to irq<<1.
- pending  out  NSRC  pending register, status readback.
- mask  out  NSRC  current enable mask.
- in_service  out  1  high from ack until eoi.
- spurious  out  1  sticky; set by ack outside ASSERT or eoi outside SERVICE; cleared only by reset.

Behaviour:
- Reset (reset_n=0 at a posedge):
  - pending=0, mask=0, interrupt=0, irq=0, in_service=0, spurious=0, state=IDLE.
  - req_prev<=req, so a request already high at reset release produces no edge.
- Edge capture, every cycle:
  - edge = req & ~req_prev; req_prev<=req.
  - pending <= (pending & ~clr) | edge.
  - Set wins over clear in the same cycle.
- Mask: when mask_we=1, mask<=mask_wdata after that posedge. Masked sources still latch into pending.
- Selection: eligible = pending & mask. Winner = lowest set index (source 0 has highest priority). No winner if eligible=0.
- State IDLE:
  - If a winner exists, go to ASSERT with irq<=winner and interrupt<=1.
  - Latency: req rising sampled at edge k → pending bit set after edge k → interrupt=1 after edge k+1.
- State ASSERT:
  - interrupt stays 1 and irq is frozen; no re-arbitration, so a higher-priority arrival waits.
  - On ack: clr[irq]=1, interrupt<=0, in_service<=1, go to SERVICE.
  - If the selected source becomes ineligible (mask bit cleared) without ack: interrupt<=0, go to IDLE; pending is kept.
  - ack takes precedence over a same-cycle mask clear.
- State SERVICE:
  - interrupt=0; no nesting; new edges keep accumulating in pending.
  - On eoi: in_service<=0, go to IDLE.
  - The next winner is presented no earlier than 1 cycle after returning to IDLE, giving one guaranteed low cycle on interrupt between services.
- Simultaneous ack and eoi: handled by current state only; the pulse that does not apply sets spurious.
- Same-source edge in the ack cycle: pending bit stays 1 and is serviced again later.
- Reset mid-operation: returns to IDLE immediately; all outputs take reset values on the next edge.
- irq holds its last value while interrupt=0; the CPU must ignore irq when interrupt=0.

Decomposition:
- Shared package holds:
  - state typedef {IDLE, ASSERT, SERVICE} (2-bit encoding).
  - NSRC and IDW defaults.
  - function prio_enc(vector) → {valid, index}, lowest index wins.
- One sub-module is natural: irq_prio_enc (combinational, NSRC → IDW+valid), reusable for a future nested-priority version.
- Edge capture and the FSM stay in the top module.

Test Plan:
- Reset: hold req=8'h04 through reset, mask=8'hFF after release → no edge, interrupt stays 0, pending=0.
- Single source: mask=8'h04, pulse req[2] → interrupt=1, irq=2 two cycles after sampling; ack → pending[2]=0, in_service=1; eoi → IDLE, interrupt stays 0.
- Priority: req[5] and req[1] rise in the same cycle, mask=8'hFF → irq=1 first; after ack+eoi, irq=5 presented with ≥1 low cycle between.
- No preemption: in ASSERT with irq=5, raise req[0] → irq stays 5 until ack; irq=0 follows after eoi.
- Masking: mask=8'h00, pulse req[3] → pending=8'h08, interrupt=0; write mask=8'h08 → interrupt=1, irq=3 next cycle. During ASSERT, write mask=0 → interrupt drops, pending[3] stays 1.
- Corner cases:
  - ack in the same cycle as a req[2] edge for the served source → pending[2] remains 1 and is re-presented after eoi.
  - eoi while IDLE → spurious=1 and state unchanged.
